// File: rtl/lut_config_loader.sv
// -----------------------------------------------------------------------------
// lut_config_loader
//
// Configuration front end for the LUT-based universal shift register fabric.
// A serial bitstream (MSB first, qualified by cfg_bit_valid) is framed as:
//
//   [8-bit sync header][NUM_WORDS x WORD_W-bit words][8-bit checksum]
//
// Each word ({sel_bit, 32-bit truth table}) is written to the fabric's LUT
// memory by index. The checksum is the count of '1' bits across all word
// payload bits, modulo 256. The fabric stays idle until done is raised.
//
// Ports:
//   clock          system clock, rising edge
//   reset_n        asynchronous active-low reset
//   cfg_start      one-cycle pulse starting a load (ignored while busy)
//   cfg_abort      aborts a load in progress (wins over cfg_start while busy)
//   cfg_bit        serial stream bit
//   cfg_bit_valid  qualifies cfg_bit; may be gapped
//   wr_en          one-cycle LUT memory write strobe
//   wr_addr        word index being written
//   wr_data        assembled word, first received bit at the MSB
//   busy           high while in SYNC, LOAD or CHECK
//   done           sticky: load completed with a matching checksum
//   error          sticky: load failed
//   err_code       01 bad sync, 10 bad checksum, 11 aborted, 00 none
//   words_loaded   words written in the current load
// -----------------------------------------------------------------------------
module lut_config_loader #(
  parameter int          NUM_WORDS = 24,
  parameter int          WORD_W    = 33,
  parameter int          ADDR_W    = 5,
  parameter logic [7:0]  SYNC_WORD = 8'hA5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic              cfg_bit,
  input  logic              cfg_bit_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_SYNC     = 2'b01,
    ERR_CHECKSUM = 2'b10,
    ERR_ABORT    = 2'b11
  } err_e;

  // Bit counter only ever needs to reach WORD_W-1 (words are the longest field).
  localparam int               CNT_W         = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BYTE_BIT = CNT_W'(7);
  localparam logic [CNT_W-1:0] LAST_WORD_BIT = CNT_W'(WORD_W - 1);
  localparam logic [ADDR_W:0]  LAST_WORD_IDX = (ADDR_W + 1)'(NUM_WORDS - 1);

  state_e              state_q,    state_d;
  logic [CNT_W-1:0]    bit_cnt_q,  bit_cnt_d;
  logic [WORD_W-1:0]   shift_q,    shift_d;
  logic [7:0]          csum_q,     csum_d;
  logic [ADDR_W:0]     words_q,    words_d;
  logic                wr_en_q,    wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q,  wr_addr_d;
  logic [WORD_W-1:0]   wr_data_q,  wr_data_d;
  logic                done_q,     done_d;
  logic                error_q,    error_d;
  err_e                err_code_q, err_code_d;

  // Shift register contents after consuming the current bit. Header and
  // checksum bytes are read from its low 8 bits once 8 bits have entered.
  logic [WORD_W-1:0]   shift_nxt;
  assign shift_nxt = {shift_q[WORD_W-2:0], cfg_bit};

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    csum_d     = csum_q;
    words_d    = words_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = done_q;
    error_d    = error_q;
    err_code_d = err_code_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        // Start beats a simultaneous abort here; bits are ignored.
        if (cfg_start) begin
          state_d    = S_SYNC;
          bit_cnt_d  = '0;
          shift_d    = '0;
          csum_d     = '0;
          words_d    = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
        end
      end

      S_SYNC, S_LOAD, S_CHECK: begin
        if (cfg_abort) begin
          // Abort wins over start and over a word completing this edge.
          state_d    = S_ERR;
          error_d    = 1'b1;
          err_code_d = ERR_ABORT;
        end else if (cfg_bit_valid) begin
          shift_d   = shift_nxt;
          bit_cnt_d = bit_cnt_q + 1'b1;
          unique case (state_q)
            S_SYNC: begin
              if (bit_cnt_q == LAST_BYTE_BIT) begin
                bit_cnt_d = '0;
                if (shift_nxt[7:0] == SYNC_WORD) begin
                  state_d = S_LOAD;
                end else begin
                  state_d    = S_ERR;
                  error_d    = 1'b1;
                  err_code_d = ERR_SYNC;
                end
              end
            end
            S_LOAD: begin
              csum_d = csum_q + {7'd0, cfg_bit};
              if (bit_cnt_q == LAST_WORD_BIT) begin
                bit_cnt_d = '0;
                wr_en_d   = 1'b1;
                wr_addr_d = words_q[ADDR_W-1:0];
                wr_data_d = shift_nxt;
                words_d   = words_q + 1'b1;
                if (words_q == LAST_WORD_IDX) state_d = S_CHECK;
              end
            end
            default: begin  // S_CHECK
              if (bit_cnt_q == LAST_BYTE_BIT) begin
                bit_cnt_d = '0;
                if (shift_nxt[7:0] == csum_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                end else begin
                  state_d    = S_ERR;
                  error_d    = 1'b1;
                  err_code_d = ERR_CHECKSUM;
                end
              end
            end
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      csum_q     <= '0;
      words_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      csum_q     <= csum_d;
      words_q    <= words_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign busy         = (state_q == S_SYNC) || (state_q == S_LOAD) || (state_q == S_CHECK);
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_code_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_lut_config_loader.sv
// -----------------------------------------------------------------------------
// Directed testbench for lut_config_loader (NUM_WORDS = 2). Inputs change on
// the falling edge, the DUT acts on the rising edge, and outputs are sampled
// on the following falling edge. A monitor logs every wr_en pulse.
// -----------------------------------------------------------------------------
module tb_lut_config_loader;

  localparam int          NUM_WORDS = 2;
  localparam int          WORD_W    = 33;
  localparam int          ADDR_W    = 5;
  localparam logic [7:0]  SYNC_WORD = 8'hA5;

  localparam logic [WORD_W-1:0] W0 = 33'h0CCCCAAAA;
  localparam logic [WORD_W-1:0] W1 = 33'h1000000AC;

  logic              clock;
  logic              reset_n;
  logic              cfg_start;
  logic              cfg_abort;
  logic              cfg_bit;
  logic              cfg_bit_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  int n_cmp = 0;
  int n_bad = 0;

  lut_config_loader #(
    .NUM_WORDS (NUM_WORDS),
    .WORD_W    (WORD_W),
    .ADDR_W    (ADDR_W),
    .SYNC_WORD (SYNC_WORD)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .cfg_start     (cfg_start),
    .cfg_abort     (cfg_abort),
    .cfg_bit       (cfg_bit),
    .cfg_bit_valid (cfg_bit_valid),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_code      (err_code),
    .words_loaded  (words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Write monitor: logs each strobe and counts strobes wider than one cycle.
  logic [ADDR_W-1:0] log_addr[$];
  logic [WORD_W-1:0] log_data[$];
  logic              prev_wr_en = 1'b0;
  int                wide_cnt   = 0;

  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      if (prev_wr_en) wide_cnt++;
    end
    prev_wr_en = (wr_en === 1'b1);
  end

  // ---------------------------------------------------------------- drivers
  task automatic idle_inputs();
    @(negedge clock);
    cfg_start     = 1'b0;
    cfg_abort     = 1'b0;
    cfg_bit_valid = 1'b0;
    cfg_bit       = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    cfg_start     = 1'b1;
    cfg_bit_valid = 1'b0;
    @(negedge clock);
    cfg_start     = 1'b0;
  endtask

  // Sends the low n bits of val, MSB first. Ungapped: returns with the last
  // bit still presented (not yet consumed). Gapped: valid toggles 1/0.
  task automatic send_bits(input logic [WORD_W-1:0] val, input int n, input bit gapped);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clock);
      cfg_bit       = val[i];
      cfg_bit_valid = 1'b1;
      if (gapped) begin
        @(negedge clock);
        cfg_bit_valid = 1'b0;
      end
    end
  endtask

  task automatic run_stream(input logic [7:0] csum, input bit gapped);
    pulse_start();
    send_bits(WORD_W'(SYNC_WORD), 8, gapped);
    send_bits(W0, WORD_W, gapped);
    send_bits(W1, WORD_W, gapped);
    send_bits(WORD_W'(csum), 8, gapped);
  endtask

  // Checks that exactly the two reference writes were logged from index base.
  task automatic check_two_writes(input string tag, input int base);
    n_cmp++;
    if (log_addr.size() - base !== 2) begin
      $display("FAIL %s write_count: got %0d, want 2", tag, log_addr.size() - base);
      n_bad++;
    end else begin
      n_cmp += 2;
      if (log_addr[base] !== 5'd0 || log_data[base] !== W0) begin
        $display("FAIL %s write0: got addr %0d data %h, want addr 0 data %h",
                 tag, log_addr[base], log_data[base], W0);
        n_bad++;
      end
      if (log_addr[base+1] !== 5'd1 || log_data[base+1] !== W1) begin
        $display("FAIL %s write1: got addr %0d data %h, want addr 1 data %h",
                 tag, log_addr[base+1], log_data[base+1], W1);
        n_bad++;
      end
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    reset_n = 1'b0;
    cfg_start = 1'b0; cfg_abort = 1'b0; cfg_bit = 1'b0; cfg_bit_valid = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++; if (busy !== 1'b0)        begin $display("FAIL reset busy: got %b, want 0", busy); n_bad++; end
    n_cmp++; if (done !== 1'b0)        begin $display("FAIL reset done: got %b, want 0", done); n_bad++; end
    n_cmp++; if (error !== 1'b0)       begin $display("FAIL reset error: got %b, want 0", error); n_bad++; end
    n_cmp++; if (err_code !== 2'b00)   begin $display("FAIL reset err_code: got %b, want 00", err_code); n_bad++; end
    n_cmp++; if (wr_en !== 1'b0)       begin $display("FAIL reset wr_en: got %b, want 0", wr_en); n_bad++; end
    n_cmp++; if (wr_addr !== '0)       begin $display("FAIL reset wr_addr: got %h, want 0", wr_addr); n_bad++; end
    n_cmp++; if (wr_data !== '0)       begin $display("FAIL reset wr_data: got %h, want 0", wr_data); n_bad++; end
    n_cmp++; if (words_loaded !== '0)  begin $display("FAIL reset words_loaded: got %0d, want 0", words_loaded); n_bad++; end
    reset_n = 1'b1;
  endtask

  task automatic test_good_load();
    int base = log_addr.size();
    run_stream(8'h15, 1'b0);
    // Last checksum bit presented but not yet consumed.
    n_cmp++; if (done !== 1'b0) begin $display("FAIL good done_early: got %b, want 0", done); n_bad++; end
    n_cmp++; if (busy !== 1'b1) begin $display("FAIL good busy_in_check: got %b, want 1", busy); n_bad++; end
    idle_inputs();
    n_cmp++; if (done !== 1'b1)         begin $display("FAIL good done: got %b, want 1", done); n_bad++; end
    n_cmp++; if (busy !== 1'b0)         begin $display("FAIL good busy: got %b, want 0", busy); n_bad++; end
    n_cmp++; if (error !== 1'b0)        begin $display("FAIL good error: got %b, want 0", error); n_bad++; end
    n_cmp++; if (err_code !== 2'b00)    begin $display("FAIL good err_code: got %b, want 00", err_code); n_bad++; end
    n_cmp++; if (words_loaded !== 6'd2) begin $display("FAIL good words_loaded: got %0d, want 2", words_loaded); n_bad++; end
    check_two_writes("good", base);
    repeat (3) @(negedge clock);
    n_cmp++; if (done !== 1'b1) begin $display("FAIL good done_sticky: got %b, want 1", done); n_bad++; end
  endtask

  task automatic test_bad_sync();
    int base = log_addr.size();
    pulse_start();
    n_cmp++; if (done !== 1'b0) begin $display("FAIL badsync done_cleared: got %b, want 0", done); n_bad++; end
    send_bits(WORD_W'(8'h5A), 8, 1'b0);
    n_cmp++; if (error !== 1'b0) begin $display("FAIL badsync error_early: got %b, want 0", error); n_bad++; end
    idle_inputs();
    n_cmp++; if (error !== 1'b1)     begin $display("FAIL badsync error: got %b, want 1", error); n_bad++; end
    n_cmp++; if (err_code !== 2'b01) begin $display("FAIL badsync err_code: got %b, want 01", err_code); n_bad++; end
    n_cmp++; if (busy !== 1'b0)      begin $display("FAIL badsync busy: got %b, want 0", busy); n_bad++; end
    // Further valid bits are ignored in ERR.
    send_bits(W0, 12, 1'b0);
    idle_inputs();
    n_cmp++; if (log_addr.size() !== base) begin $display("FAIL badsync writes: got %0d, want 0", log_addr.size() - base); n_bad++; end
  endtask

  task automatic test_bad_checksum();
    int base = log_addr.size();
    run_stream(8'h14, 1'b0);
    idle_inputs();
    n_cmp++; if (error !== 1'b1)     begin $display("FAIL badcsum error: got %b, want 1", error); n_bad++; end
    n_cmp++; if (err_code !== 2'b10) begin $display("FAIL badcsum err_code: got %b, want 10", err_code); n_bad++; end
    n_cmp++; if (done !== 1'b0)      begin $display("FAIL badcsum done: got %b, want 0", done); n_bad++; end
    check_two_writes("badcsum", base);
  endtask

  task automatic test_gapped();
    int base = log_addr.size();
    int wide0 = wide_cnt;
    run_stream(8'h15, 1'b1);
    idle_inputs();
    n_cmp++; if (done !== 1'b1)         begin $display("FAIL gapped done: got %b, want 1", done); n_bad++; end
    n_cmp++; if (error !== 1'b0)        begin $display("FAIL gapped error: got %b, want 0", error); n_bad++; end
    n_cmp++; if (words_loaded !== 6'd2) begin $display("FAIL gapped words_loaded: got %0d, want 2", words_loaded); n_bad++; end
    n_cmp++; if (wide_cnt !== wide0)    begin $display("FAIL gapped wr_en_width: got %0d wide pulses, want 0", wide_cnt - wide0); n_bad++; end
    check_two_writes("gapped", base);
  endtask

  task automatic test_abort_mid_word();
    int base = log_addr.size();
    pulse_start();
    send_bits(WORD_W'(SYNC_WORD), 8, 1'b0);
    send_bits(W0, WORD_W, 1'b0);
    send_bits(W1 >> 23, 10, 1'b0);
    @(negedge clock);
    cfg_bit_valid = 1'b0;
    cfg_abort     = 1'b1;
    idle_inputs();
    n_cmp++; if (error !== 1'b1)        begin $display("FAIL abort error: got %b, want 1", error); n_bad++; end
    n_cmp++; if (err_code !== 2'b11)    begin $display("FAIL abort err_code: got %b, want 11", err_code); n_bad++; end
    n_cmp++; if (words_loaded !== 6'd1) begin $display("FAIL abort words_loaded: got %0d, want 1", words_loaded); n_bad++; end
    n_cmp++; if (busy !== 1'b0)         begin $display("FAIL abort busy: got %b, want 0", busy); n_bad++; end
    n_cmp++; if (log_addr.size() - base !== 1) begin $display("FAIL abort writes: got %0d, want 1", log_addr.size() - base); n_bad++; end
  endtask

  task automatic test_abort_on_completion();
    int base = log_addr.size();
    pulse_start();
    send_bits(WORD_W'(SYNC_WORD), 8, 1'b0);
    send_bits(W0 >> 1, WORD_W - 1, 1'b0);
    @(negedge clock);
    cfg_bit       = W0[0];
    cfg_bit_valid = 1'b1;
    cfg_abort     = 1'b1;
    idle_inputs();
    n_cmp++; if (wr_en !== 1'b0)        begin $display("FAIL abortcpl wr_en: got %b, want 0", wr_en); n_bad++; end
    n_cmp++; if (words_loaded !== 6'd0) begin $display("FAIL abortcpl words_loaded: got %0d, want 0", words_loaded); n_bad++; end
    n_cmp++; if (err_code !== 2'b11)    begin $display("FAIL abortcpl err_code: got %b, want 11", err_code); n_bad++; end
    repeat (2) @(negedge clock);
    n_cmp++; if (log_addr.size() !== base) begin $display("FAIL abortcpl writes: got %0d, want 0", log_addr.size() - base); n_bad++; end
  endtask

  task automatic test_start_abort_priority();
    // In ERR, start with abort: start wins.
    @(negedge clock);
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    idle_inputs();
    n_cmp++; if (busy !== 1'b1)      begin $display("FAIL prio start_wins busy: got %b, want 1", busy); n_bad++; end
    n_cmp++; if (err_code !== 2'b00) begin $display("FAIL prio start_wins err_code: got %b, want 00", err_code); n_bad++; end
    // Start while busy is ignored: header split around a stray start pulse.
    send_bits(WORD_W'(SYNC_WORD >> 4), 4, 1'b0);
    pulse_start();
    send_bits(WORD_W'(SYNC_WORD), 4, 1'b0);
    send_bits(W0, WORD_W, 1'b0);
    idle_inputs();
    n_cmp++; if (words_loaded !== 6'd1) begin $display("FAIL prio start_ignored words_loaded: got %0d, want 1", words_loaded); n_bad++; end
    // Busy, start with abort: abort wins.
    @(negedge clock);
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    idle_inputs();
    n_cmp++; if (busy !== 1'b0)      begin $display("FAIL prio abort_wins busy: got %b, want 0", busy); n_bad++; end
    n_cmp++; if (err_code !== 2'b11) begin $display("FAIL prio abort_wins err_code: got %b, want 11", err_code); n_bad++; end
  endtask

  task automatic test_reset_mid_load();
    int base;
    pulse_start();
    send_bits(WORD_W'(SYNC_WORD), 8, 1'b0);
    send_bits(W0, WORD_W, 1'b0);
    send_bits(W1 >> 28, 5, 1'b0);
    // Assert reset between edges and sample before any rising edge.
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0)        begin $display("FAIL rstmid busy: got %b, want 0", busy); n_bad++; end
    n_cmp++; if (words_loaded !== '0)  begin $display("FAIL rstmid words_loaded: got %0d, want 0", words_loaded); n_bad++; end
    n_cmp++; if (wr_data !== '0)       begin $display("FAIL rstmid wr_data: got %h, want 0", wr_data); n_bad++; end
    n_cmp++; if (error !== 1'b0 || err_code !== 2'b00 || done !== 1'b0) begin
      $display("FAIL rstmid flags: got done %b error %b code %b, want 0 0 00", done, error, err_code); n_bad++;
    end
    idle_inputs();
    reset_n = 1'b1;
    base = log_addr.size();
    run_stream(8'h15, 1'b0);
    idle_inputs();
    n_cmp++; if (done !== 1'b1)         begin $display("FAIL rstmid reload done: got %b, want 1", done); n_bad++; end
    n_cmp++; if (words_loaded !== 6'd2) begin $display("FAIL rstmid reload words_loaded: got %0d, want 2", words_loaded); n_bad++; end
    check_two_writes("rstmid_reload", base);
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_sync();
    test_bad_checksum();
    test_gapped();
    test_abort_mid_word();
    test_abort_on_completion();
    test_start_abort_priority();
    test_reset_mid_load();
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
